// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared defaults and types for the free-running cycle counter
package counter_pkg;

    localparam int CNT_WIDTH_DEF   = 5;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/counter_5b_if.sv
// rtl/counter_5b_if.sv - count output bundle; the counter drives it, consumers observe it
interface counter_5b_if
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) ();

    logic [WIDTH-1:0] ocnt;

    modport master (output ocnt);
    modport slave  (input  ocnt);

endinterface

// File: rtl/reset_release_sync.sv
// rtl/reset_release_sync.sv - async-assert, sync-release reset synchroniser producing a run enable
module reset_release_sync
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic run_en
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("reset_release_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Every stage reads "in reset" (1); a 0 is shifted in from the bottom on release.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign run_en = ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/counter_5b.sv
// rtl/counter_5b.sv - free-running wrap counter with async clear and synchronised reset release
module counter_5b
    import counter_pkg::*;
#(
    parameter int WIDTH       = CNT_WIDTH_DEF,
    parameter int MAX_VAL     = 2**WIDTH - 1,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    counter_5b_if.master       cnt_if
);

    if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
        $error("counter_5b: MAX_VAL must lie in 1 .. 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = MAX_VAL[WIDTH-1:0];

    logic             run_en;
    logic [WIDTH-1:0] ocnt_q;
    logic [WIDTH-1:0] ocnt_d;

    reset_release_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_en (run_en)
    );

    always_comb begin
        ocnt_d = ocnt_q;
        if (run_en) begin
            ocnt_d = (ocnt_q < MAX_CNT) ? ocnt_q + WIDTH'(1) : '0;
        end
    end

    // rst_n is active-high despite its name: 1 clears the count without a clock.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ocnt_q <= '0;
        end else begin
            ocnt_q <= ocnt_d;
        end
    end

    assign cnt_if.ocnt = ocnt_q;

    a_cnt_in_range : assert property (@(posedge clk) ocnt_q <= MAX_CNT);
    a_cnt_zero_in_reset : assert property (@(posedge clk) rst_n |-> ocnt_q == '0);

endmodule

// File: tb/tb_counter_5b.sv
// tb/tb_counter_5b.sv - scoreboard bench for counter_5b with default and swept parameters
module tb_counter_5b;
    import counter_pkg::*;

    typedef struct {
        string name;
        int    exp;
    } exp_t;

    logic clk;
    logic clk_en;
    logic rst_a;
    logic rst_b;

    int checks   = 0;
    int failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    counter_5b_if #(.WIDTH(5)) if_a ();
    counter_5b_if #(.WIDTH(4)) if_b ();

    counter_5b dut_a (
        .clk    (clk),
        .rst_n  (rst_a),
        .cnt_if (if_a.master)
    );

    counter_5b #(
        .WIDTH       (4),
        .MAX_VAL     (9),
        .SYNC_STAGES (3)
    ) dut_b (
        .clk    (clk),
        .rst_n  (rst_b),
        .cnt_if (if_b.master)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Scoreboard monitor: one queued expectation per rising edge, checked on the falling edge.
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            exp_t e;
            e = q_a.pop_front();
            checks++;
            if (int'(if_a.ocnt) !== e.exp) begin
                failures++;
                $display("FAIL %s: ocnt=%0d expected=%0d", e.name, if_a.ocnt, e.exp);
            end
        end
        if (q_b.size() > 0) begin
            exp_t e;
            e = q_b.pop_front();
            checks++;
            if (int'(if_b.ocnt) !== e.exp) begin
                failures++;
                $display("FAIL %s: ocnt=%0d expected=%0d", e.name, if_b.ocnt, e.exp);
            end
        end
    end

    task automatic check_now(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: ocnt=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic edge_a(input string name, input int exp);
        exp_t e;
        @(posedge clk);
        e.name = name;
        e.exp  = exp;
        q_a.push_back(e);
    endtask

    task automatic edge_b(input string name, input int exp);
        exp_t e;
        @(posedge clk);
        e.name = name;
        e.exp  = exp;
        q_b.push_back(e);
    endtask

    // Release latency (SYNC_STAGES=2): edges 1,2 -> 0, then edge k -> (k-2) mod 32.
    int rel_tab[5] = '{0, 0, 1, 2, 3};

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk_en = 1'b0;
        clk    = 1'bx;
        rst_a  = 1'bx;
        rst_b  = 1'bx;
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check_now("x_startup_a", int'(if_a.ocnt), 0);
        check_now("x_startup_b", int'(if_b.ocnt), 0);

        clk = 1'b0;
        #20;
        check_now("reset_clk_stopped", int'(if_a.ocnt), 0);
        clk_en = 1'b1;

        for (int i = 0; i < 64; i++) edge_a("reset_hold", 0);

        @(negedge clk);
        #1 rst_a = 1'b0;
        for (int k = 1; k <= 5; k++) edge_a($sformatf("release_edge%0d", k), rel_tab[k-1]);
        for (int k = 6; k <= 40; k++) begin
            if (k == 33)      edge_a("edge33_max", 31);
            else if (k == 34) edge_a("edge34_wrap", 0);
            else if (k == 40) edge_a("edge40", 6);
            else              edge_a($sformatf("run_edge%0d", k), (k - 2) % 32);
        end
        for (int k = 41; k <= 51; k++) edge_a($sformatf("run_edge%0d", k), (k - 2) % 32);

        // Count is 17 now; assert reset between edges and expect an immediate clear.
        @(negedge clk);
        #1 rst_a = 1'b1;
        #1 check_now("midcount_async_clear", int'(if_a.ocnt), 0);
        for (int i = 0; i < 64; i++) edge_a("midcount_reset_hold", 0);

        @(negedge clk);
        #1 rst_a = 1'b0;
        edge_a("rerelease_edge1", 0);
        edge_a("rerelease_edge2", 0);
        edge_a("rerelease_edge3", 1);
        edge_a("rerelease_edge4", 2);

        // Swept instance: WIDTH=4, MAX_VAL=9, SYNC_STAGES=3.
        @(negedge clk);
        #1 rst_b = 1'b0;
        edge_b("sweep_edge1", 0);
        edge_b("sweep_edge2", 0);
        edge_b("sweep_edge3", 0);
        for (int v = 1; v <= 9; v++) edge_b($sformatf("sweep_val%0d", v), v);
        edge_b("sweep_wrap", 0);
        edge_b("sweep_after_wrap", 1);

        @(negedge clk);
        @(negedge clk);
        check_now("scoreboard_drained", q_a.size() + q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
